// File: rtl/spi_slave_regbridge_if.sv
// spi_slave_regbridge_if: SPI pins plus fabric register bus of the SPI register bridge.
//   spi_sclk/spi_ss_n/spi_mosi : from SPI master
//   spi_miso/spi_miso_oe       : to SPI master (tristate resolved at top level)
//   reg_addr/reg_wdata/reg_wr/reg_rd : register strobes toward fabric logic
//   reg_rdata                  : read data from fabric, valid 1 clk after reg_rd
//   frame_active/frame_err     : frame status
interface spi_slave_regbridge_if #(parameter int ADDR_W = 7);
    logic              spi_sclk;
    logic              spi_ss_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [7:0]        reg_rdata;
    logic              frame_active;
    logic              frame_err;
    modport slave (
        input  spi_sclk, spi_ss_n, spi_mosi, reg_rdata,
        output spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_wr, reg_rd, frame_active, frame_err
    );
    modport master (
        output spi_sclk, spi_ss_n, spi_mosi, reg_rdata,
        input  spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_wr, reg_rd, frame_active, frame_err
    );
endinterface

// File: rtl/spi_slave_regbridge.sv
// spi_slave_regbridge: oversampled SPI mode-0 slave turning {rw,addr} + data bytes into register strobes.
//   clk_clk       : fabric clock (>= 8x SCLK)
//   reset_reset_n : asynchronous active-low reset
//   bus           : slave modport carrying SPI pins, register bus and frame status
module spi_slave_regbridge #(
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input logic                   clk_clk,
    input logic                   reset_reset_n,
    spi_slave_regbridge_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CMD   = 2'd1;
    localparam logic [1:0] S_WDATA = 2'd2;
    localparam logic [1:0] S_RDATA = 2'd3;
    logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync, r_vld;
    logic                   r_sclk_prev, r_armed;
    logic [1:0]             r_state;
    logic [2:0]             r_bitcnt;
    logic [6:0]             r_rx;
    logic [7:0]             r_tx, r_wdata;
    logic [ADDR_W-1:0]      r_addr;
    logic                   r_wr, r_rd, r_cap, r_inc, r_err;
    logic                   w_sclk, w_ss, w_mosi, w_sel, w_act, w_rise, w_fall, w_done, w_end;
    logic [7:0]             w_byte;
    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss   = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    // A frame only counts once ss_n has been seen high with a fully refilled synchronizer,
    // so a reset in the middle of a frame ignores the rest of that frame.
    assign w_sel  = ~w_ss & r_armed;
    assign w_act  = w_sel & (r_state != S_IDLE);
    assign w_rise = w_act & w_sclk & ~r_sclk_prev;
    assign w_fall = w_act & ~w_sclk & r_sclk_prev;
    assign w_done = w_rise & (r_bitcnt == 3'd7);
    assign w_end  = w_ss & (r_state != S_IDLE);
    assign w_byte = {r_rx, w_mosi};
    assign bus.frame_active = w_sel;
    assign bus.spi_miso_oe  = w_sel;
    assign bus.spi_miso     = (r_state == S_RDATA) & r_tx[7];
    assign bus.reg_addr     = r_addr;
    assign bus.reg_wdata    = r_wdata;
    assign bus.reg_wr       = r_wr;
    assign bus.reg_rd       = r_rd;
    assign bus.frame_err    = r_err;
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '1;
            r_vld       <= '0;
            r_sclk_prev <= 1'b0;
            r_armed     <= 1'b0;
            r_state     <= S_IDLE;
            r_bitcnt    <= 3'd0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_wdata     <= '0;
            r_addr      <= '0;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_cap       <= 1'b0;
            r_inc       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], bus.spi_ss_n};
            r_vld       <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_sclk_prev <= w_sclk;
            if (r_vld[SYNC_STAGES-1] & w_ss) r_armed <= 1'b1;
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_err <= 1'b0;
            r_inc <= 1'b0;
            r_cap <= r_rd;
            // The fall right after a byte's last rise must present the freshly captured MSB, so no shift then.
            if (r_cap) r_tx <= bus.reg_rdata;
            else if (w_fall & (r_state == S_RDATA) & (r_bitcnt != 3'd0)) r_tx <= {r_tx[6:0], 1'b0};
            if (r_inc) r_addr <= r_addr + ADDR_W'(1);
            if (w_rise) begin
                r_rx     <= w_byte[6:0];
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_end) begin
                r_state  <= S_IDLE;
                r_bitcnt <= 3'd0;
                r_err    <= (r_bitcnt != 3'd0);
            end else if (r_state == S_IDLE) begin
                if (w_sel) begin
                    r_state  <= S_CMD;
                    r_bitcnt <= 3'd0;
                    r_tx     <= '0;
                end
            end else if (w_done) begin
                if (r_state == S_CMD) begin
                    r_addr  <= w_byte[ADDR_W-1:0];
                    r_rd    <= w_byte[7];
                    r_state <= w_byte[7] ? S_RDATA : S_WDATA;
                end else if (r_state == S_WDATA) begin
                    r_wr    <= 1'b1;
                    r_wdata <= w_byte;
                    r_inc   <= 1'b1;
                end else begin
                    r_addr  <= r_addr + ADDR_W'(1);
                    r_rd    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_regbridge.sv
// tb_spi_slave_regbridge: randomized and directed SPI frames against a behavioural register-bridge model.
module tb_spi_slave_regbridge;
    logic clk, rst_n;
    int n_run = 0, n_fail = 0;
    spi_slave_regbridge_if #(.ADDR_W(7)) bus();
    spi_slave_regbridge #(.ADDR_W(7), .SYNC_STAGES(2)) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .bus(bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    logic [7:0] regs [0:127];
    logic [7:0] f_tx [0:64];
    logic [7:0] f_rx [0:64];
    logic [6:0] wr_a[$], rd_a[$];
    logic [7:0] wr_d[$];
    int err_n, miso_hi;
    always @(posedge clk) if (bus.reg_rd) bus.reg_rdata <= regs[bus.reg_addr];
    always @(negedge clk) begin
        if (bus.reg_wr) begin
            wr_a.push_back(bus.reg_addr);
            wr_d.push_back(bus.reg_wdata);
        end
        if (bus.reg_rd) rd_a.push_back(bus.reg_addr);
        if (bus.frame_err) err_n++;
        if (bus.spi_miso) miso_hi++;
    end
    task automatic clr();
        wr_a.delete();
        wr_d.delete();
        rd_a.delete();
        err_n = 0;
        miso_hi = 0;
    endtask
    task automatic spi_bit(input logic b, output logic m);
        bus.spi_mosi = b;
        repeat (4) @(negedge clk);
        m = bus.spi_miso;
        bus.spi_sclk = 1'b1;
        repeat (4) @(negedge clk);
        bus.spi_sclk = 1'b0;
    endtask
    task automatic spi_byte(input logic [7:0] d, input int n, output logic [7:0] m);
        logic b;
        m = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_bit(d[7-i], b);
            m[7-i] = b;
        end
    endtask
    task automatic frame(input int nb, input int xb);
        logic [7:0] m;
        clr();
        bus.spi_ss_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            spi_byte(f_tx[i], 8, m);
            f_rx[i] = m;
        end
        if (xb > 0) spi_byte(f_tx[nb], xb, m);
        repeat (4) @(negedge clk);
        bus.spi_ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_run++;
        if ({bus.spi_miso, bus.spi_miso_oe, bus.reg_addr, bus.reg_wdata, bus.reg_wr, bus.reg_rd, bus.frame_active, bus.frame_err} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got %h want 0", {bus.spi_miso, bus.spi_miso_oe, bus.reg_addr, bus.reg_wdata, bus.reg_wr, bus.reg_rd, bus.frame_active, bus.frame_err});
        end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_run++;
        if ({bus.frame_active, bus.spi_miso_oe} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle select: got %b want 00", {bus.frame_active, bus.spi_miso_oe});
        end
    endtask
    task automatic test_write_single();
        f_tx[0] = 8'h05; f_tx[1] = 8'hA7;
        frame(2, 0);
        n_run++;
        if ({wr_a.size(), rd_a.size(), err_n, miso_hi} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL wr_single counts: got wr=%0d rd=%0d err=%0d miso_hi=%0d want 1 0 0 0", wr_a.size(), rd_a.size(), err_n, miso_hi);
        end
        n_run++;
        if ({wr_a[0], wr_d[0]} !== {7'h05, 8'hA7}) begin
            n_fail++;
            $display("FAIL wr_single: got addr=%h data=%h want 05 a7", wr_a[0], wr_d[0]);
        end
    endtask
    task automatic test_write_wrap();
        logic [6:0] ea [0:2] = '{7'h7E, 7'h7F, 7'h00};
        logic [7:0] ed [0:2] = '{8'h11, 8'h22, 8'h33};
        f_tx[0] = 8'h7E; f_tx[1] = 8'h11; f_tx[2] = 8'h22; f_tx[3] = 8'h33;
        frame(4, 0);
        n_run++;
        if ({wr_a.size(), err_n, miso_hi} !== {32'd3, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL wr_wrap counts: got wr=%0d err=%0d miso_hi=%0d want 3 0 0", wr_a.size(), err_n, miso_hi);
        end
        for (int k = 0; k < 3; k++) begin
            n_run++;
            if ({wr_a[k], wr_d[k]} !== {ea[k], ed[k]}) begin
                n_fail++;
                $display("FAIL wr_wrap[%0d]: got addr=%h data=%h want %h %h", k, wr_a[k], wr_d[k], ea[k], ed[k]);
            end
        end
    endtask
    task automatic test_read_burst();
        regs[3] = 8'h3C; regs[4] = 8'hC3;
        f_tx[0] = 8'h83; f_tx[1] = 8'h00; f_tx[2] = 8'h00;
        frame(3, 0);
        n_run++;
        if ({rd_a.size(), wr_a.size(), err_n} !== {32'd3, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL rd_burst counts: got rd=%0d wr=%0d err=%0d want 3 0 0", rd_a.size(), wr_a.size(), err_n);
        end
        n_run++;
        if ({rd_a[0], rd_a[1], rd_a[2]} !== {7'd3, 7'd4, 7'd5}) begin
            n_fail++;
            $display("FAIL rd_burst addrs: got %h %h %h want 03 04 05", rd_a[0], rd_a[1], rd_a[2]);
        end
        n_run++;
        if ({f_rx[0], f_rx[1], f_rx[2]} !== {8'h00, 8'h3C, 8'hC3}) begin
            n_fail++;
            $display("FAIL rd_burst miso: got %h %h %h want 00 3c c3", f_rx[0], f_rx[1], f_rx[2]);
        end
    endtask
    task automatic test_cmd_only();
        f_tx[0] = 8'h85;
        frame(1, 0);
        n_run++;
        if ({rd_a.size(), rd_a[0], wr_a.size(), err_n} !== {32'd1, 7'h05, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL rd_cmd_only: got rd=%0d a=%h wr=%0d err=%0d want 1 05 0 0", rd_a.size(), rd_a[0], wr_a.size(), err_n);
        end
        f_tx[0] = 8'h05;
        frame(1, 0);
        n_run++;
        if ({wr_a.size(), rd_a.size(), err_n} !== {32'd0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL wr_cmd_only: got wr=%0d rd=%0d err=%0d want 0 0 0", wr_a.size(), rd_a.size(), err_n);
        end
    endtask
    task automatic test_partial();
        f_tx[0] = 8'h10; f_tx[1] = 8'hFF;
        frame(1, 5);
        n_run++;
        if ({wr_a.size(), rd_a.size(), err_n} !== {32'd0, 32'd0, 32'd1}) begin
            n_fail++;
            $display("FAIL partial: got wr=%0d rd=%0d err=%0d want 0 0 1", wr_a.size(), rd_a.size(), err_n);
        end
        n_run++;
        if ({bus.frame_active, bus.spi_miso_oe, bus.spi_miso} !== 3'b000) begin
            n_fail++;
            $display("FAIL partial idle: got %b want 000", {bus.frame_active, bus.spi_miso_oe, bus.spi_miso});
        end
        f_tx[0] = 8'h2A; f_tx[1] = 8'h6B;
        frame(2, 0);
        n_run++;
        if ({wr_a.size(), wr_a[0], wr_d[0], err_n} !== {32'd1, 7'h2A, 8'h6B, 32'd0}) begin
            n_fail++;
            $display("FAIL after_partial: got n=%0d a=%h d=%h err=%0d want 1 2a 6b 0", wr_a.size(), wr_a[0], wr_d[0], err_n);
        end
    endtask
    task automatic test_random();
        logic [6:0] a;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 64; i++) f_tx[i] = 8'($urandom);
            if (f < 2) f_tx[0][7] = f[0];
            a = f_tx[0][6:0];
            frame(64, 0);
            if (f_tx[0][7]) begin
                n_run++;
                if ({rd_a.size(), wr_a.size(), err_n} !== {32'd64, 32'd0, 32'd0}) begin
                    n_fail++;
                    $display("FAIL rnd%0d rd counts: got rd=%0d wr=%0d err=%0d want 64 0 0", f, rd_a.size(), wr_a.size(), err_n);
                end
                for (int k = 0; k < 64; k++) begin
                    n_run++;
                    if (rd_a[k] !== 7'(a + k)) begin
                        n_fail++;
                        $display("FAIL rnd%0d rd_addr[%0d]: got %h want %h", f, k, rd_a[k], 7'(a + k));
                    end
                end
                for (int k = 1; k < 64; k++) begin
                    n_run++;
                    if (f_rx[k] !== regs[7'(a + k - 1)]) begin
                        n_fail++;
                        $display("FAIL rnd%0d miso[%0d]: got %h want %h", f, k, f_rx[k], regs[7'(a + k - 1)]);
                    end
                end
            end else begin
                n_run++;
                if ({wr_a.size(), rd_a.size(), err_n, miso_hi} !== {32'd63, 32'd0, 32'd0, 32'd0}) begin
                    n_fail++;
                    $display("FAIL rnd%0d wr counts: got wr=%0d rd=%0d err=%0d miso_hi=%0d want 63 0 0 0", f, wr_a.size(), rd_a.size(), err_n, miso_hi);
                end
                for (int k = 0; k < 63; k++) begin
                    n_run++;
                    if ({wr_a[k], wr_d[k]} !== {7'(a + k), f_tx[k+1]}) begin
                        n_fail++;
                        $display("FAIL rnd%0d wr[%0d]: got %h %h want %h %h", f, k, wr_a[k], wr_d[k], 7'(a + k), f_tx[k+1]);
                    end
                end
            end
        end
    endtask
    task automatic test_reset_mid();
        logic [7:0] m;
        clr();
        bus.spi_ss_n = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(8'h83, 8, m);
        spi_byte(8'h00, 5, m);
        rst_n = 1'b0;
        #1;
        n_run++;
        if ({bus.spi_miso, bus.spi_miso_oe, bus.reg_addr, bus.reg_wdata, bus.reg_wr, bus.reg_rd, bus.frame_active, bus.frame_err} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got %h want 0", {bus.spi_miso, bus.spi_miso_oe, bus.reg_addr, bus.reg_wdata, bus.reg_wr, bus.reg_rd, bus.frame_active, bus.frame_err});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clr();
        spi_byte(8'h00, 3, m);
        spi_byte(8'h00, 8, m);
        bus.spi_ss_n = 1'b1;
        repeat (8) @(negedge clk);
        n_run++;
        if ({wr_a.size(), rd_a.size(), err_n} !== {32'd0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_mid ignored: got wr=%0d rd=%0d err=%0d want 0 0 0", wr_a.size(), rd_a.size(), err_n);
        end
        f_tx[0] = 8'h12; f_tx[1] = 8'h5A;
        frame(2, 0);
        n_run++;
        if ({wr_a.size(), wr_a[0], wr_d[0], err_n} !== {32'd1, 7'h12, 8'h5A, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_mid next: got n=%0d a=%h d=%h err=%0d want 1 12 5a 0", wr_a.size(), wr_a[0], wr_d[0], err_n);
        end
        f_tx[0] = 8'h8A; f_tx[1] = 8'h00;
        frame(2, 0);
        n_run++;
        if ({rd_a.size(), rd_a[0], f_rx[1]} !== {32'd2, 7'h0A, regs[10]}) begin
            n_fail++;
            $display("FAIL reset_mid read: got n=%0d a=%h miso=%h want 2 0a %h", rd_a.size(), rd_a[0], f_rx[1], regs[10]);
        end
    endtask
    initial begin
        for (int i = 0; i < 128; i++) regs[i] = 8'($urandom);
        bus.spi_sclk = 1'b0;
        bus.spi_ss_n = 1'b1;
        bus.spi_mosi = 1'b0;
        clr();
        test_reset();
        test_write_single();
        test_write_wrap();
        test_read_burst();
        test_cmd_only();
        test_partial();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave_regbridge.md
Name: spi_slave_regbridge

Overview:
- SPI mode-0 slave in the FPGA fabric. It is the responder for the HPS SPI master (spim0/spim1 routed to the fabric).
- Decodes a command byte followed by data bytes. Turns them into single-cycle register read/write strobes toward fabric logic.
- Supports burst transfers with address auto-increment.
- SCLK/MOSI/SS_N are oversampled in the fabric clock domain. No SCLK-clocked logic.

Parameters:
- ADDR_W, 7, register address width. Command byte is {rw, addr[6:0]}; only addr[ADDR_W-1:0] is used. Legal range 1..7.
- SYNC_STAGES, 2, synchronizer depth on spi_sclk, spi_mosi and spi_ss_n. Minimum 2.

Ports:
- clk_clk  in  1  fabric clock. Must be ≥ 8× SCLK frequency.
- reset_reset_n  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock from master, idle low (CPOL=0).
- spi_ss_n  in  1  slave select, active low.
- spi_mosi  in  1  master-out data. Sampled on SCLK rising edge.
- spi_miso  out  1  slave-out data. Changes after SCLK falling edge.
- spi_miso_oe  out  1  MISO output enable (tristate done at top level).
- reg_addr  out  ADDR_W  register address.
- reg_wdata  out  8  write data.
- reg_wr  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data. Valid exactly 1 clk after reg_rd.
- frame_active  out  1  high while synchronized ss_n is low.
- frame_err  out  1  one-cycle pulse when a frame ends on a partial byte.

Behaviour:
- Reset values: every output 0; state IDLE; address register 0; bit count 0.
- Synchronization and edges:
  - spi_sclk, spi_mosi and spi_ss_n each pass through SYNC_STAGES flops.
  - rise/fall = synchronized sclk current vs previous value.
  - MOSI is sampled on rise. Since it is synchronized alongside SCLK, no extra skew compensation is applied.
- Select / output enable: frame_active = ~ss_sync. spi_miso_oe = frame_active.
- Shift: MSB first, 3-bit bit counter, 8-bit shift register.
  - A byte completes on the rise that shifts in bit 0.
  - Rises and falls are ignored while ss_sync is high.
- States:
  - IDLE → CMD on ss_sync falling. Clear bit count; spi_miso = 0.
  - CMD, byte complete: addr ← byte[ADDR_W-1:0]. If byte[7] = 1 go to RDATA; else go to WDATA.
  - Entering RDATA: reg_rd pulses in the cycle after byte completion, with reg_addr = addr. On the following cycle, capture reg_rdata into tx shift register.
  - RDATA:
    - spi_miso = tx[7], valid from capture onward.
    - On each fall, shift tx left by one.
    - On byte completion: addr ← addr+1, reg_rd for the new address, recapture tx. The falling edge after bit 0's rise then presents the new MSB.
  - WDATA, byte complete: reg_wr = 1 for one cycle with reg_addr = addr and reg_wdata = byte. addr increments the following cycle. spi_miso = 0 throughout.
  - During CMD, spi_miso = 0.
- Timing budget: the read pipeline takes 1 clk (strobe) + 1 clk (capture) after the synchronized rise. It must finish before the next fall, which arrives ≥ 4 clk later at the 8× ratio.
- Address wrap: addr increments modulo 2^ADDR_W (all-ones → 0).
- Frame end (ss_sync rises in any state):
  - Return to IDLE; spi_miso = 0.
  - If bit count ≠ 0: pulse frame_err for 1 cycle and discard the partial byte (no reg_wr).
  - Completed bytes already strobed stand.
  - A frame containing only a command byte performs no write. A read-command-only frame still issues one reg_rd.
- Simultaneous events: an ss_sync rise in the same cycle as a rise is treated as frame end; that edge is discarded.
- Asynchronous reset mid-frame: immediate return to reset values. The remainder of the frame is ignored until ss_n is seen high, then low again.

Test Plan:
- Write single: ss_n low, send 0x05, 0xA7, ss_n high → one reg_wr with reg_addr=0x05, reg_wdata=0xA7; frame_err never pulses; miso = 0 throughout.
- Write burst with wrap: send 0x7E, 0x11, 0x22, 0x33 → reg_wr at addr 0x7E/0x7F/0x00 with data 0x11/0x22/0x33.
- Read burst: send 0x83 then 16 dummy clocks; model returns 0x3C for addr 3 and 0xC3 for addr 4 → reg_rd at 3 then 4 (and 5 on the final byte); master samples 0x3C, 0xC3.
- Partial byte: send 0x10 + 5 bits, then ss_n high → no reg_wr, one frame_err pulse, state IDLE, miso_oe = 0.
- SCLK at exactly clk/8 with SYNC_STAGES=2, random 64-byte read/write frames vs reference model → zero mismatches.
- Reset asserted mid-read burst → all outputs 0 immediately; next full frame decodes correctly.
